// File: rtl/physmem_pkg.sv
// Shared types and constants for the physical-memory controller slice.
package physmem_pkg;

  localparam int LINE_BYTES = 16;
  localparam int CNT_W      = 16;

  typedef logic [8*LINE_BYTES-1:0] line_t;
  typedef logic [LINE_BYTES-1:0]   sel_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

endpackage

// File: rtl/physmem_array.sv
// Single-port, byte-enabled line RAM: combinational read, write on enable.
module physmem_array
  import physmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  line_t                 wdata,
  input  sel_t                  sel,
  output line_t                 rdata
);

  line_t mem [2**DEPTH_LOG2];

  // NOTE: the storage array has no reset branch so it can map onto a plain RAM macro.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LINE_BYTES; i++) begin
        if (sel[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/physmem_ctrl.sv
// Wishbone slave line memory with fixed access latency and saturating access counters.
// Optional open-row latency model is enabled by defining PHYSMEM_OPEN_ROW_EN.
module physmem_ctrl
  import physmem_pkg::*;
#(
  parameter int ADDR_BITS      = 28,
  parameter int DEPTH_LOG2     = 10,
  parameter int READ_LAT       = 4,
  parameter int WRITE_LAT      = 4,
  parameter int ROW_LINES_LOG2 = 3,
  parameter int HIT_LAT        = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [ADDR_BITS-1:0] ADR,
  input  line_t                DAT_M,
  input  sel_t                 SEL,
  input  logic                 CYC,
  input  logic                 STB,
  input  logic                 WE,
  output line_t                DAT_S,
  output logic                 ACK,
  output logic                 RTY,
  output logic                 oob_err,
  output logic [31:0]          rd_count,
  output logic [31:0]          wr_count
);

  typedef logic [DEPTH_LOG2-1:0] idx_t;

  if (READ_LAT < 1 || WRITE_LAT < 1 || HIT_LAT < 1 ||
      ROW_LINES_LOG2 >= DEPTH_LOG2 || DEPTH_LOG2 >= ADDR_BITS) begin : g_bad_cfg
    $error("physmem_ctrl: invalid parameter set");
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] acc_lat;
  logic             req, acc_oob, acc_hit, commit, mem_we;

  idx_t  adr_q;
  logic  we_q, oob_q;
  sel_t  sel_q;
  line_t dat_q;

  idx_t  cur_adr;
  logic  cur_we, cur_oob;
  sel_t  cur_sel;
  line_t cur_dat;
  line_t rdata;

  assign req     = CYC & STB;
  assign acc_oob = (ADR >> DEPTH_LOG2) != '0;

  // Live bus fields are used on the accepting edge (LAT=1 commits there), latched ones afterwards.
  assign cur_adr = (state == IDLE) ? ADR[DEPTH_LOG2-1:0] : adr_q;
  assign cur_we  = (state == IDLE) ? WE      : we_q;
  assign cur_oob = (state == IDLE) ? acc_oob : oob_q;
  assign cur_sel = (state == IDLE) ? SEL     : sel_q;
  assign cur_dat = (state == IDLE) ? DAT_M   : dat_q;

`ifdef PHYSMEM_OPEN_ROW_EN
  localparam int ROW_W = DEPTH_LOG2 - ROW_LINES_LOG2;

  logic             row_valid;
  logic [ROW_W-1:0] open_row;

  assign acc_hit = row_valid && !acc_oob && (ADR[DEPTH_LOG2-1:ROW_LINES_LOG2] == open_row);

  always_ff @(posedge CLK) begin
    if (RST) begin
      row_valid <= 1'b0;
      open_row  <= '0;
    end else if (commit) begin
      row_valid <= !cur_oob;
      open_row  <= cur_adr[DEPTH_LOG2-1:ROW_LINES_LOG2];
    end
  end
`else
  assign acc_hit = 1'b0;
`endif

  always_comb begin
    if (acc_hit)  acc_lat = CNT_W'(HIT_LAT);
    else if (WE)  acc_lat = CNT_W'(WRITE_LAT);
    else          acc_lat = CNT_W'(READ_LAT);
  end

  // NOTE: state and datapath flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (req) state_nxt = (acc_lat == CNT_W'(1)) ? RESP : BUSY;
      BUSY: begin
        if (!req)                     state_nxt = IDLE;
        else if (cnt == CNT_W'(1))    state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A transaction commits on the edge that enters RESP; an abort or reset there loses it.
  assign commit = (state_nxt == RESP) && (state != RESP);
  assign mem_we = commit && cur_we && !cur_oob && !RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt      <= '0;
      oob_err  <= 1'b0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (state == IDLE && req)
        cnt <= acc_lat - CNT_W'(1);
      else if (state == BUSY && req && cnt != CNT_W'(1))
        cnt <= cnt - CNT_W'(1);

      if (commit && cur_oob) oob_err <= 1'b1;

      if (state == RESP) begin
        if (we_q) begin
          if (wr_count != '1) wr_count <= wr_count + 32'd1;
        end else begin
          if (rd_count != '1) rd_count <= rd_count + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (state == IDLE && req) begin
      adr_q <= ADR[DEPTH_LOG2-1:0];
      we_q  <= WE;
      oob_q <= acc_oob;
      sel_q <= SEL;
      dat_q <= DAT_M;
    end
  end

  physmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (CLK),
    .we   (mem_we),
    .addr (cur_adr),
    .wdata(cur_dat),
    .sel  (cur_sel),
    .rdata(rdata)
  );

  // NOTE: every output gets a default first so this block can never infer a latch.
  always_comb begin
    ACK   = 1'b0;
    DAT_S = '0;
    if (state == RESP) begin
      ACK = 1'b1;
      if (!we_q && !oob_q) DAT_S = rdata;
    end
  end

  assign RTY = 1'b0;

endmodule

// File: tb/tb_physmem_ctrl.sv
// Directed bench for physmem_ctrl: transaction-level model plus a per-cycle compare process.
module tb_physmem_ctrl;

  localparam int ADDR_BITS      = 28;
  localparam int DEPTH_LOG2     = 10;
  localparam int READ_LAT       = 4;
  localparam int WRITE_LAT      = 4;
  localparam int ROW_LINES_LOG2 = 3;
  localparam int HIT_LAT        = 1;

  logic                 CLK = 1'b0;
  logic                 RST = 1'b1;
  logic [ADDR_BITS-1:0] ADR = '0;
  logic [127:0]         DAT_M = '0;
  logic [15:0]          SEL = '0;
  logic                 CYC = 1'b0;
  logic                 STB = 1'b0;
  logic                 WE = 1'b0;
  logic [127:0]         DAT_S;
  logic                 ACK, RTY, oob_err;
  logic [31:0]          rd_count, wr_count;

  always #5 CLK = ~CLK;

  physmem_ctrl #(
    .ADDR_BITS(ADDR_BITS), .DEPTH_LOG2(DEPTH_LOG2), .READ_LAT(READ_LAT),
    .WRITE_LAT(WRITE_LAT), .ROW_LINES_LOG2(ROW_LINES_LOG2), .HIT_LAT(HIT_LAT)
  ) dut (
    .CLK(CLK), .RST(RST), .ADR(ADR), .DAT_M(DAT_M), .SEL(SEL), .CYC(CYC), .STB(STB),
    .WE(WE), .DAT_S(DAT_S), .ACK(ACK), .RTY(RTY), .oob_err(oob_err),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state: memory contents, counters, sticky error, open row, pending ACK expectation.
  logic [127:0] m_mem [int];
  logic [31:0]  m_rd = '0, m_wr = '0;
  bit           m_oob = 1'b0;
  bit           m_row_valid = 1'b0;
  int           m_row = 0;
  bit           pend_rd = 1'b0, pend_wr = 1'b0;
  int           exp_ack_at = -1;
  bit           exp_we = 1'b0, exp_oob = 1'b0, exp_known = 1'b0;
  logic [127:0] exp_dat = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] merge(input logic [127:0] old_line, input logic [127:0] new_line,
                                         input logic [15:0] sel);
    logic [127:0] r;
    r = old_line;
    for (int i = 0; i < 16; i++) if (sel[i]) r[8*i +: 8] = new_line[8*i +: 8];
    return r;
  endfunction

  function automatic int model_lat(input bit we, input int line, input bit oob);
    int l;
    l = we ? WRITE_LAT : READ_LAT;
`ifdef PHYSMEM_OPEN_ROW_EN
    if (!oob && m_row_valid && ((line >> ROW_LINES_LOG2) == m_row)) l = HIT_LAT;
`else
    if (oob && line < 0) l = 0;
`endif
    return l;
  endfunction

  // Compare process: one sample per cycle, 1 time unit after the active edge.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (RST) begin
        m_rd = '0; m_wr = '0; m_oob = 1'b0; pend_rd = 1'b0; pend_wr = 1'b0;
      end else begin
        if (pend_rd && m_rd != 32'hFFFF_FFFF) m_rd++;
        if (pend_wr && m_wr != 32'hFFFF_FFFF) m_wr++;
        pend_rd = 1'b0;
        pend_wr = 1'b0;
        if (cyc == exp_ack_at) begin
          if (exp_oob) m_oob = 1'b1;
          pend_rd = !exp_we;
          pend_wr = exp_we;
        end
      end
      check("ack", ACK, (!RST && cyc == exp_ack_at));
      if (!RST && cyc == exp_ack_at && exp_known) check("dat_s", DAT_S, exp_dat);
      check("rd_count", rd_count, m_rd);
      check("wr_count", wr_count, m_wr);
      check("oob_err", oob_err, m_oob);
      check("rty", RTY, 1'b0);
    end
  end

  // Complete transaction; called and returns at a falling edge. ack_k = falling edges until ACK seen.
  task automatic xact(input bit we, input logic [ADDR_BITS-1:0] adr, input logic [127:0] dat,
                      input logic [15:0] sel, output int ack_k, output logic [127:0] ack_dat);
    int line, lat;
    bit oob;
    line = int'(adr);
    oob  = (line >= (1 << DEPTH_LOG2));
    lat  = model_lat(we, line, oob);
    exp_we  = we;
    exp_oob = oob;
    if (we) begin
      exp_dat   = '0;
      exp_known = 1'b1;
      if (!oob && (sel == 16'hFFFF || m_mem.exists(line)))
        m_mem[line] = merge(m_mem.exists(line) ? m_mem[line] : '0, dat, sel);
    end else if (oob) begin
      exp_dat   = '0;
      exp_known = 1'b1;
    end else if (m_mem.exists(line)) begin
      exp_dat   = m_mem[line];
      exp_known = 1'b1;
    end else begin
      exp_known = 1'b0;
    end
    if (oob) m_row_valid = 1'b0;
    else begin
      m_row_valid = 1'b1;
      m_row       = line >> ROW_LINES_LOG2;
    end
    exp_ack_at = cyc + lat;
    WE = we; ADR = adr; DAT_M = dat; SEL = sel; CYC = 1'b1; STB = 1'b1;
    ack_k   = -1;
    ack_dat = '0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        ADR = adr ^ 28'h7; DAT_M = ~dat; SEL = ~sel;
      end
      if (ACK && ack_k < 0) begin
        ack_k   = k;
        ack_dat = DAT_S;
      end
    end
    @(negedge CLK);
    CYC = 1'b0; STB = 1'b0;
  endtask

  task automatic abort_write(input logic [ADDR_BITS-1:0] adr, input logic [127:0] dat);
    exp_ack_at = -1;
    WE = 1'b1; ADR = adr; DAT_M = dat; SEL = 16'hFFFF; CYC = 1'b1; STB = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    STB = 1'b0;
    @(negedge CLK);
    CYC = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic rst_mid_read(input logic [ADDR_BITS-1:0] adr);
    exp_ack_at = -1;
    WE = 1'b0; ADR = adr; SEL = 16'hFFFF; CYC = 1'b1; STB = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0; CYC = 1'b0; STB = 1'b0;
    m_row_valid = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic do_rst();
    RST = 1'b1; CYC = 1'b0; STB = 1'b0;
    exp_ack_at  = -1;
    m_row_valid = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [127:0] d;
    logic [127:0] pat;
    logic [15:0]  sels [4];
    sels = '{16'h0001, 16'h8000, 16'hF0F0, 16'h0000};
    pat  = 128'h0F0E0D0C0B0A09080706050403020100;

    @(negedge CLK);
    do_rst();
    check("rst_ack", ACK, 1'b0);
    check("rst_dat_s", DAT_S, 128'h0);
    check("rst_rd_count", rd_count, 32'd0);
    check("rst_wr_count", wr_count, 32'd0);
    check("rst_oob_err", oob_err, 1'b0);

    // Read after reset: ACK on the 4th cycle after acceptance.
    xact(1'b0, 28'h10, '0, 16'hFFFF, k, d);
    check("first_read_lat", k, 4);
    check("first_read_rd_count", rd_count, 32'd1);

    // Byte-masked write merged with prior contents.
    xact(1'b1, 28'h20, {16{8'hAA}}, 16'hFFFF, k, d);
    check("first_write_lat", k, 4);
    xact(1'b1, 28'h20, pat, 16'h00FF, k, d);
    xact(1'b0, 28'h20, '0, 16'hFFFF, k, d);
    check("merge_data", d, 128'hAAAAAAAAAAAAAAAA_0706050403020100);
    check("merge_wr_count", wr_count, 32'd2);
    check("merge_rd_count", rd_count, 32'd2);

    // Aborted write leaves memory and counters untouched.
    xact(1'b1, 28'h30, {16{8'h5A}}, 16'hFFFF, k, d);
    abort_write(28'h30, {16{8'hC3}});
    check("abort_wr_count", wr_count, 32'd3);
    xact(1'b0, 28'h30, '0, 16'hFFFF, k, d);
    check("abort_old_data", d, {16{8'h5A}});

    // Out-of-range accesses: normal latency, zero data, dropped write, sticky flag.
    xact(1'b1, 28'h001, {16{8'h11}}, 16'hFFFF, k, d);
    xact(1'b0, 28'h400, '0, 16'hFFFF, k, d);
    check("oob_read_lat", k, 4);
    check("oob_read_data", d, 128'h0);
    check("oob_flag_set", oob_err, 1'b1);
    xact(1'b1, 28'h401, {16{8'hEE}}, 16'hFFFF, k, d);
    xact(1'b0, 28'h001, '0, 16'hFFFF, k, d);
    check("oob_write_dropped", d, {16{8'h11}});
    check("oob_flag_sticky", oob_err, 1'b1);
    check("oob_rd_count", rd_count, 32'd5);
    check("oob_wr_count", wr_count, 32'd5);

    // Reset in the second cycle of a read: no ACK, then a normal transaction.
    rst_mid_read(28'h20);
    check("midrst_rd_count", rd_count, 32'd0);
    check("midrst_oob_err", oob_err, 1'b0);
    xact(1'b0, 28'h20, '0, 16'hFFFF, k, d);
    check("after_rst_lat", k, 4);
    check("after_rst_data", d, 128'hAAAAAAAAAAAAAAAA_0706050403020100);
    check("after_rst_rd_count", rd_count, 32'd1);

    // Back-to-back masked writes and reads, including an empty byte mask.
    for (int i = 0; i < 4; i++) begin
      xact(1'b1, 28'h50 + 28'(i), {4{32'h1234_5600 + 32'(i)}}, 16'hFFFF, k, d);
      xact(1'b1, 28'h50 + 28'(i), {16{8'hF0 - 8'(i)}}, sels[i], k, d);
    end
    for (int i = 0; i < 4; i++) xact(1'b0, 28'h50 + 28'(i), '0, 16'hFFFF, k, d);
    check("empty_mask_data", d, {4{32'h1234_5603}});

    // Open-row latency: 0x40 miss, 0x41 same row, 0x48 new row.
    xact(1'b1, 28'h40, {16{8'h40}}, 16'hFFFF, k, d);
    xact(1'b1, 28'h41, {16{8'h41}}, 16'hFFFF, k, d);
    xact(1'b1, 28'h48, {16{8'h48}}, 16'hFFFF, k, d);
    do_rst();
    xact(1'b0, 28'h40, '0, 16'hFFFF, k, d);
    check("row_first_lat", k, 4);
    xact(1'b0, 28'h41, '0, 16'hFFFF, k, d);
`ifdef PHYSMEM_OPEN_ROW_EN
    check("row_hit_lat", k, 1);
`else
    check("row_hit_lat", k, 4);
`endif
    check("row_hit_data", d, {16{8'h41}});
    xact(1'b0, 28'h48, '0, 16'hFFFF, k, d);
    check("row_new_lat", k, 4);
    check("row_new_data", d, {16{8'h48}});

    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
